// File: rtl/lcd_bus_reader_pkg.sv
// Shared types and timing defaults for the HD44780 read-side bus transactor.
package lcd_bus_reader_pkg;

  // Transaction phases of one read strobe plus arbitration.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_ENABLE  = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RECOVER = 3'd5
  } state_e;

  // Register select values on the RS pin.
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  // Busy flag position in the status byte.
  localparam int BF_BIT = 7;

  // Default phase lengths in CLOCK_50 cycles, shared with the write driver.
  localparam int T_AS_DEF      = 4;
  localparam int T_PW_DEF      = 24;
  localparam int T_H_DEF       = 2;
  localparam int T_REC_DEF     = 20;
  localparam int MAX_POLLS_DEF = 255;

  // Phase counter preload: a phase of n cycles counts n-1 down to 0.
  function automatic logic [7:0] phase_load(input int cycles);
    return 8'(cycles - 1);
  endfunction

  // Phases during which the pins carry a read cycle (RW high, RS valid).
  function automatic logic pins_read_phase(input state_e s);
    return (s == ST_SETUP) || (s == ST_ENABLE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/lcd_bus_reader_if.sv
// Request/response and LCD pin bundle of the read transactor.
// master: the surrounding logic (requester, pin mux and pad); slave: the transactor.
interface lcd_bus_reader_if;

  logic       req;
  logic       req_rs;
  logic       wait_req;
  logic       busy;
  logic       ack;
  logic       ready;
  logic       timeout;
  logic [7:0] rdata;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] lcd_data_in;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  modport master (
    output req, req_rs, wait_req, bus_gnt, lcd_data_in,
    input  busy, ack, ready, timeout, rdata, bus_req, lcd_rs, lcd_rw, lcd_en
  );

  modport slave (
    input  req, req_rs, wait_req, bus_gnt, lcd_data_in,
    output busy, ack, ready, timeout, rdata, bus_req, lcd_rs, lcd_rw, lcd_en
  );

endinterface

// File: rtl/lcd_bus_reader_phase_timer.sv
// Loadable 8-bit down-counter timing each bus phase; done while the count is zero.
module lcd_bus_reader_phase_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       done_o
);

  logic [7:0] cnt_q, cnt_d;

  // Next count: a load wins, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/lcd_bus_reader.sv
// HD44780 read transactor: single reads of BF/AC or data RAM, and a wait-ready
// mode that re-strobes the status register until BF clears or the poll budget runs out.
module lcd_bus_reader
  import lcd_bus_reader_pkg::*;
#(
  parameter int T_AS      = T_AS_DEF,
  parameter int T_PW      = T_PW_DEF,
  parameter int T_H       = T_H_DEF,
  parameter int T_REC     = T_REC_DEF,
  parameter int MAX_POLLS = MAX_POLLS_DEF
) (
  input logic              clock,
  input logic              reset,
  lcd_bus_reader_if.slave  bus
);

  localparam logic [7:0] LAST_POLL = 8'(MAX_POLLS - 1);

  state_e     state_q, state_d;
  logic       rs_q, rs_d;
  logic       wait_mode_q, wait_mode_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic       ready_q, ready_d;
  logic       timeout_q, timeout_d;
  logic       bus_req_q, bus_req_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic       lcd_rw_q, lcd_rw_d;
  logic       lcd_en_q, lcd_en_d;

  logic       tmr_load_s;
  logic [7:0] tmr_val_s;
  logic       tmr_done_s;

  lcd_bus_reader_phase_timer u_phase_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_load_s),
    .load_val_i (tmr_val_s),
    .done_o     (tmr_done_s)
  );

  // Next-state, result pulses and pin values; pins are decoded from the next state so they are registered.
  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    wait_mode_d = wait_mode_q;
    poll_cnt_d  = poll_cnt_q;
    rdata_d     = rdata_q;
    ack_d       = 1'b0;
    ready_d     = 1'b0;
    timeout_d   = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_val_s   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        // A simultaneous wait_req loses to req and is dropped, not queued.
        if (bus.req) begin
          rs_d        = bus.req_rs;
          wait_mode_d = 1'b0;
          poll_cnt_d  = 8'd0;
          state_d     = ST_ARB;
        end else if (bus.wait_req) begin
          rs_d        = RS_CMD;
          wait_mode_d = 1'b1;
          poll_cnt_d  = 8'd0;
          state_d     = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ARB: begin
        if (bus.bus_gnt) begin
          state_d    = ST_SETUP;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_load(T_AS);
        end else begin
          state_d = ST_ARB;
        end
      end

      ST_SETUP: begin
        if (tmr_done_s) begin
          state_d    = ST_ENABLE;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_load(T_PW);
        end else begin
          state_d = ST_SETUP;
        end
      end

      ST_ENABLE: begin
        // The pad is sampled only on the last E-high cycle, when the LCD output is settled.
        if (tmr_done_s) begin
          rdata_d    = bus.lcd_data_in;
          state_d    = ST_HOLD;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_load(T_H);
        end else begin
          state_d = ST_ENABLE;
        end
      end

      ST_HOLD: begin
        if (tmr_done_s) begin
          state_d    = ST_RECOVER;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_load(T_REC);
        end else begin
          state_d = ST_HOLD;
        end
      end

      ST_RECOVER: begin
        if (!tmr_done_s) begin
          state_d = ST_RECOVER;
        end else if (!wait_mode_q) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
        end else if (!rdata_q[BF_BIT]) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else if (poll_cnt_q == LAST_POLL) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          // Keep the bus and go straight into the next status strobe.
          poll_cnt_d = poll_cnt_q + 8'd1;
          state_d    = ST_SETUP;
          tmr_load_s = 1'b1;
          tmr_val_s  = phase_load(T_AS);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d    = (state_d != ST_IDLE) || ack_d || ready_d || timeout_d;
    bus_req_d = (state_d != ST_IDLE);
    lcd_rw_d  = pins_read_phase(state_d);
    lcd_rs_d  = lcd_rw_d ? rs_d : RS_CMD;
    lcd_en_d  = (state_d == ST_ENABLE);
  end

  // State, captured data and registered outputs; reset forces every pin and flag low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rs_q        <= RS_CMD;
      wait_mode_q <= 1'b0;
      poll_cnt_q  <= 8'd0;
      rdata_q     <= 8'h00;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      ready_q     <= 1'b0;
      timeout_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_rw_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      wait_mode_q <= wait_mode_d;
      poll_cnt_q  <= poll_cnt_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      ready_q     <= ready_d;
      timeout_q   <= timeout_d;
      bus_req_q   <= bus_req_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_rw_q    <= lcd_rw_d;
      lcd_en_q    <= lcd_en_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.ack     = ack_q;
  assign bus.ready   = ready_q;
  assign bus.timeout = timeout_q;
  assign bus.rdata   = rdata_q;
  assign bus.bus_req = bus_req_q;
  assign bus.lcd_rs  = lcd_rs_q;
  assign bus.lcd_rw  = lcd_rw_q;
  assign bus.lcd_en  = lcd_en_q;

endmodule
